// File: rtl/dmem_subword.sv
// Byte-addressed RV32 data memory with sub-word loads/stores, sign/zero
// extension, misalignment rejection, one-cycle req/done handshake and an
// optional sequential zero-clear of every word after reset.
module dmem_subword #(
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_dm,
  input  logic              rst_dm,
  input  logic              mem_req,
  output logic              mem_ready,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       mw_data,
  output logic [31:0]       m_r_data,
  output logic              mem_done,
  output logic              mem_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  clr_ptr_reg;
  logic              clear_active;

  logic              accept;
  logic              misaligned;
  logic [IDX_W-1:0]  acc_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [3:0]        wr_en;
  logic [31:0]       wr_data;
  logic [3:0]        store_be;
  logic [31:0]       store_data;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       load_data;

  logic [31:0]       m_r_data_reg;
  logic              mem_done_reg;
  logic              mem_err_reg;

  // State register: reset always lands in CLEAR
  always_ff @(posedge clk_dm) begin
    if (rst_dm) state_reg <= ST_CLEAR;
    else        state_reg <= state_next;
  end

  // Next state: leave CLEAR after the last word is zeroed (or at once when clearing is off)
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (!CLEAR_ON_RESET || (clr_ptr_reg == IDX_W'(DEPTH - 1)))
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only when idle, clear writes only in CLEAR
  always_comb begin
    mem_ready    = (state_reg == ST_IDLE);
    clear_active = (state_reg == ST_CLEAR) && CLEAR_ON_RESET;
  end

  // Clear pointer walks every word once, held at zero during reset
  always_ff @(posedge clk_dm) begin
    if (rst_dm)            clr_ptr_reg <= '0;
    else if (clear_active) clr_ptr_reg <= clr_ptr_reg + 1'b1;
  end

  assign accept  = mem_req && mem_ready && !rst_dm;
  assign acc_idx = dm_addr[ADDR_W-1:2];

  // Access decode: alignment legality and store lane placement
  always_comb begin
    misaligned = 1'b0;
    store_be   = 4'b0000;
    store_data = mw_data;
    case (mem_size)
      2'b00: begin
        store_be   = 4'b0001 << dm_addr[1:0];
        store_data = {4{mw_data[7:0]}};
      end
      2'b01: begin
        misaligned = dm_addr[0];
        store_be   = dm_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{mw_data[15:0]}};
      end
      2'b10: begin
        misaligned = (dm_addr[1:0] != 2'b00);
        store_be   = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Write port mux: clear sweep or an accepted legal store, never during reset
  always_comb begin
    wr_en   = 4'b0000;
    wr_idx  = acc_idx;
    wr_data = store_data;
    if (!rst_dm && clear_active) begin
      wr_en   = 4'b1111;
      wr_idx  = clr_ptr_reg;
      wr_data = '0;
    end else if (accept && mem_we && !misaligned) begin
      wr_en = store_be;
    end
  end

  // One byte-wide array per lane so each lane has its own write enable
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Lane write
      always_ff @(posedge clk_dm) begin
        if (wr_en[gi]) lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
      end

      assign rd_word[gi*8 +: 8] = lane_mem[acc_idx];
    end
  endgenerate

  // Load alignment and extension
  always_comb begin
    rd_shift  = rd_word >> {dm_addr[1:0], 3'b000};
    load_data = rd_word;
    case (mem_size)
      2'b00:   load_data = {{24{!mem_unsigned && rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_data = {{16{!mem_unsigned && rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Response registers: done/err pulse one cycle after accept, data held across stores
  always_ff @(posedge clk_dm) begin
    if (rst_dm) begin
      m_r_data_reg <= '0;
      mem_done_reg <= 1'b0;
      mem_err_reg  <= 1'b0;
    end else begin
      mem_done_reg <= accept;
      mem_err_reg  <= accept && misaligned;
      if (accept) begin
        if (misaligned)   m_r_data_reg <= '0;
        else if (!mem_we) m_r_data_reg <= load_data;
      end
    end
  end

  assign m_r_data = m_r_data_reg;
  assign mem_done = mem_done_reg;
  assign mem_err  = mem_err_reg;

endmodule

// File: tb/tb_dmem_subword.sv
// Self-checking bench for dmem_subword: directed vector table, hand-written
// reset/pipelining sequences, and random accesses against a byte-array model.
module tb_dmem_subword;

  logic        clk_dm = 1'b0;
  always #5 clk_dm = ~clk_dm;

  logic        rst_dm, mem_req, mem_ready, mem_we, mem_unsigned, mem_done, mem_err;
  logic [1:0]  mem_size;
  logic [7:0]  dm_addr;
  logic [31:0] mw_data, m_r_data;

  logic        b_rst, b_req, b_ready, b_we, b_unsigned, b_done, b_err;
  logic [1:0]  b_size;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;

  dmem_subword #(.ADDR_W(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_dm(clk_dm), .rst_dm(rst_dm), .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .dm_addr(dm_addr), .mw_data(mw_data), .m_r_data(m_r_data),
    .mem_done(mem_done), .mem_err(mem_err)
  );

  dmem_subword #(.ADDR_W(8), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk_dm(clk_dm), .rst_dm(b_rst), .mem_req(b_req), .mem_ready(b_ready),
    .mem_we(b_we), .mem_size(b_size), .mem_unsigned(b_unsigned),
    .dm_addr(b_addr), .mw_data(b_wdata), .m_r_data(b_rdata),
    .mem_done(b_done), .mem_err(b_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: plain byte array plus the expected held load result
  logic [7:0]  mm [256];
  logic [31:0] exp_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit legal(input logic [1:0] size, input logic [7:0] addr);
    int a = int'(addr);
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return (a % 2) == 0;
      2'd2:    return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns, input logic [7:0] addr);
    int a = int'(addr);
    longint v;
    case (size)
      2'd0: begin
        v = mm[a];
        if (!uns && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = mm[a] + 256 * mm[a+1];
        if (!uns && v >= 32768) v = v - 65536;
      end
      default: v = mm[a] + 256 * mm[a+1] + 65536 * mm[a+2] + 16777216 * longint'(mm[a+3]);
    endcase
    return 32'(v);
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [7:0] addr, input logic [31:0] wd);
    int a = int'(addr);
    int n = 1 << size;
    for (int i = 0; i < n; i++) mm[a+i] = wd[8*i +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mm[i] = 8'h00;
    exp_rdata = 32'h0;
  endtask

  // One access cycle: drive, let the edge accept it, then check the response.
  // mem_req is left high so consecutive calls form a back-to-back stream.
  task automatic access(input bit we, input logic [1:0] size, input bit uns,
                        input logic [7:0] addr, input logic [31:0] wd, input string tag);
    bit ok;
    mem_req = 1'b1; mem_we = we; mem_size = size; mem_unsigned = uns;
    dm_addr = addr; mw_data = wd;
    @(posedge clk_dm); #1;
    ok = legal(size, addr);
    if (!ok)      exp_rdata = 32'h0;
    else if (we)  model_store(size, addr, wd);
    else          exp_rdata = model_load(size, uns, addr);
    chk({tag, " done"}, {31'b0, mem_done}, 32'd1);
    chk({tag, " err"},  {31'b0, mem_err},  {31'b0, !ok});
    chk({tag, " rdata"}, m_r_data, exp_rdata);
    $display("%s we=%0d size=%0d uns=%0d addr=%h wd=%h -> rdata=%h err=%0d",
             tag, we, size, uns, addr, wd, m_r_data, mem_err);
  endtask

  task automatic idle(input string tag);
    mem_req = 1'b0;
    @(posedge clk_dm); #1;
    chk({tag, " idle done"}, {31'b0, mem_done}, 32'd0);
    chk({tag, " idle err"},  {31'b0, mem_err},  32'd0);
    chk({tag, " idle rdata"}, m_r_data, exp_rdata);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int n;
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 8'h04, 32'h12345678, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 8'h04, 32'h0,        32'h12345678, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 8'h07, 32'h0,        32'h00000012, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 8'h06, 32'h0,        32'h00001234, 1'b0};
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 8'h05, 32'hFFFFFF80, 32'h00001234, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 8'h04, 32'h0,        32'h12348078, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 8'h05, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 1'b1, 8'h05, 32'h0,        32'h00000080, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 1'b1, 8'h04, 32'h0,        32'h00008078, 1'b0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 8'h03, 32'hAAAA5555, 32'h00000000, 1'b1};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 8'h06, 32'hAAAA5555, 32'h00000000, 1'b1};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 8'h00, 32'h0,        32'h00000000, 1'b1};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 8'h00, 32'h0,        32'h00000000, 1'b0};

    rst_dm = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd2;
    mem_unsigned = 1'b0; dm_addr = 8'h0; mw_data = 32'h0;
    b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_size = 2'd2;
    b_unsigned = 1'b0; b_addr = 8'h0; b_wdata = 32'h0;
    model_clear();

    // Reset state and clear duration
    @(posedge clk_dm); #1;
    chk("reset ready", {31'b0, mem_ready}, 32'd0);
    chk("reset done",  {31'b0, mem_done},  32'd0);
    chk("reset err",   {31'b0, mem_err},   32'd0);
    chk("reset rdata", m_r_data, 32'h0);
    $display("reset applied, ready=%0d", mem_ready);
    rst_dm = 1'b0;
    n = 0;
    while (!mem_ready && n < 200) begin
      @(posedge clk_dm); #1;
      n++;
    end
    chk("clear cycles", n, 64);
    $display("clear finished after %0d cycles", n);

    // Directed vector table, issued back to back
    for (int i = 0; i < 14; i++) begin
      access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl rdata", i), m_r_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d tbl err", i), {31'b0, mem_err}, {31'b0, vecs[i].exp_err});
    end
    idle("vec");

    // Store then load on the very next cycle with req held high
    access(1'b1, 2'd2, 1'b0, 8'h20, 32'hCAFEBABE, "raw sw");
    access(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, "raw lw");
    chk("raw lw value", m_r_data, 32'hCAFEBABE);
    idle("raw");

    // Random accesses against the model
    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      logic [7:0] ad;
      if (($urandom % 5) == 0) begin
        idle("rnd");
      end else begin
        sz = 2'($urandom_range(0, 3));
        ad = 8'($urandom);
        if (($urandom % 4) != 0) begin
          if (sz == 2'd1) ad[0] = 1'b0;
          if (sz == 2'd2) ad[1:0] = 2'b00;
        end
        access(1'($urandom), sz, 1'($urandom), ad, $urandom, $sformatf("rnd%0d", i));
      end
    end
    idle("rnd end");

    // Reset wins over a simultaneous store; requests during clear are ignored
    access(1'b1, 2'd2, 1'b0, 8'h08, 32'h11111111, "pre sw08");
    access(1'b1, 2'd2, 1'b0, 8'h0C, 32'h22222222, "pre sw0c");
    rst_dm = 1'b1; mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2;
    dm_addr = 8'h08; mw_data = 32'hDEADBEEF;
    @(posedge clk_dm); #1;
    chk("rst+req done",  {31'b0, mem_done},  32'd0);
    chk("rst+req ready", {31'b0, mem_ready}, 32'd0);
    chk("rst+req rdata", m_r_data, 32'h0);
    $display("reset with simultaneous SW 0xDEADBEEF @08, done=%0d", mem_done);
    rst_dm = 1'b0;
    model_clear();
    dm_addr = 8'h0C; mw_data = 32'h33333333;
    n = 0;
    while (!mem_ready && n < 200) begin
      @(posedge clk_dm); #1;
      n++;
      chk("clear req done", {31'b0, mem_done}, 32'd0);
    end
    mem_req = 1'b0;
    chk("clear2 cycles", n, 64);
    access(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, "post lw08");
    chk("post lw08 value", m_r_data, 32'h0);
    access(1'b0, 2'd2, 1'b0, 8'h0C, 32'h0, "post lw0c");
    chk("post lw0c value", m_r_data, 32'h0);
    idle("post");

    // No-clear instance: ready one cycle after reset, contents retained
    b_rst = 1'b0;
    @(posedge clk_dm); #1;
    chk("nc ready", {31'b0, b_ready}, 32'd1);
    b_req = 1'b1; b_we = 1'b1; b_size = 2'd2; b_addr = 8'h0C; b_wdata = 32'hA5A55A5A;
    @(posedge clk_dm); #1;
    chk("nc sw done", {31'b0, b_done}, 32'd1);
    $display("nc SW A5A55A5A @0C done=%0d", b_done);
    b_req = 1'b0; b_rst = 1'b1;
    @(posedge clk_dm); #1;
    chk("nc rst ready", {31'b0, b_ready}, 32'd0);
    b_rst = 1'b0;
    @(posedge clk_dm); #1;
    chk("nc ready2", {31'b0, b_ready}, 32'd1);
    b_req = 1'b1; b_we = 1'b0;
    @(posedge clk_dm); #1;
    chk("nc lw done", {31'b0, b_done}, 32'd1);
    chk("nc lw retained", b_rdata, 32'hA5A55A5A);
    $display("nc LW @0C after reset -> %h", b_rdata);
    b_req = 1'b0;
    @(posedge clk_dm); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
